store_buffer: RTL

- Posted-write buffer between the single-cycle core's memory stage and data_memory (128 x 32-bit, 7-bit word address, combinational read, write on posedge).
- Stores retire into a small FIFO and drain to data memory in cycles with no memory instruction.
- Loads are served from the youngest matching buffered store, otherwise from data memory.
- Core stalls only when a store arrives with the buffer full.

---
 rtl/store_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Posted-write buffer between the core's memory stage and data_memory.
// Stores go into a small circular FIFO. The FIFO drains to data memory in
// cycles with no memory instruction, and also in a cycle where a store meets
// a full buffer. A load is served from the youngest buffered store to the
// same word address; if there is none, it is served from data memory.
//
// Ports
//   clk, reset_n         : clock, synchronous active-low reset
//   cpu_address          : load/store word address from the core
//   cpu_write_data       : store data from the core
//   cpu_mem_read/write   : load / store issued this cycle
//   cpu_read_data        : load result (combinational)
//   stall                : store refused this cycle (buffer full)
//   empty                : no pending entries
//   dm_*                 : data_memory port (address, write data, read/write
//                          enables, read data)
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_write_data,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    output logic [DATA_W-1:0] cpu_read_data,
    output logic              stall,
    output logic              empty,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_write_data,
    output logic              dm_mem_read,
    output logic              dm_mem_write,
    input  logic [DATA_W-1:0] dm_read_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Entry storage. Entries need no reset: validity comes from head/count.
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic full;
    logic accept;
    logic drain;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = cpu_mem_write && !full;
    assign stall  = cpu_mem_write && full;
    // When a store hits a full buffer, the head still drains so that the
    // retried store is accepted in the next cycle.
    assign drain  = !empty && !cpu_mem_read && (!cpu_mem_write || full);

    // Data-memory port mux. A load owns the address; otherwise the head
    // entry's address is presented, and it is written only when draining.
    assign dm_mem_read   = cpu_mem_read;
    assign dm_mem_write  = drain;
    assign dm_address    = cpu_mem_read ? cpu_address : addr_q[head_q];
    assign dm_write_data = data_q[head_q];

    // Forwarding match per age offset. Offset 0 is the oldest (head) entry.
    // An offset is valid only if it is below the current count.
    logic [DEPTH-1:0] hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] slot;
            assign slot    = head_q + PTR_W'(gi);
            assign hit[gi] = (CNT_W'(gi) < count_q) && (addr_q[slot] == cpu_address);
        end
    endgenerate

    // Scan from oldest to youngest so that a younger match overrides.
    always_comb begin
        cpu_read_data = dm_read_data;
        for (int k = 0; k < DEPTH; k++) begin
            if (hit[k]) begin
                cpu_read_data = data_q[head_q + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (accept) begin
            tail_d = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(accept) - CNT_W'(drain);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            addr_q[tail_q] <= cpu_address;
            data_q[tail_q] <= cpu_write_data;
        end
    end

endmodule
